digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock, using one shared DIGIT-bit ripple adder built from full-adder cells.
- Successor to the single-bit combinational full adder. Adds a carry register, a start/done handshake, a subtract mode and a signed-overflow flag.
- Sits beside the RCA/CSA/CLA blocks as the area-minimal option in the adder family.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 4, bits processed per clock; 1 <= DIGIT <= WIDTH

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
sub    input   1      0: a+b+cin; 1: a-b (cin ignored)
a      input   WIDTH  operand A, latched on accepted start
b      input   WIDTH  operand B, latched on accepted start
cin    input   1      carry-in, latched on accepted start
busy   output  1      high in RUN
done   output  1      one-cycle pulse; result valid
s      output  WIDTH  sum/difference, held until next completion
cout   output  1      carry out of MSB; for sub, 1 = no borrow
ovf    output  1      two's-complement overflow

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - busy, done, s, cout, ovf, carry register, digit counter and operand shift registers all 0.
- NDIG = WIDTH/DIGIT.
- IDLE:
  - start=1 at a rising edge latches a into opA and (sub ? ~b : b) into opB.
  - carry <= sub ? 1 : cin; cnt <= 0; state -> RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge, digit_adder adds opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Sum digit shifts into the top of the result shift register. opA/opB shift right by DIGIT. carry <= digit carry-out. cnt++.
  - On the edge where cnt==NDIG-1 (the NDIG-th digit), state -> DONE.
  - On that same edge: s <= completed result; cout <= final carry; ovf <= (carry into MSB) XOR (carry out of MSB).
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE.
- Timing:
  - Latency: start sampled at edge E0; done high in the cycle after edge E_NDIG, i.e. NDIG+1 clocks after E0.
  - Minimum start-to-start spacing: NDIG+2 clocks.
- start in RUN or DONE is ignored, not queued. Input changes after the accepting edge have no effect.
- s/cout/ovf change only on the completing edge; they hold the previous result during RUN.
- Reset mid-operation aborts immediately: outputs go to 0, no done pulse.
- DIGIT==WIDTH: NDIG=1, one RUN cycle.
- DIGIT==1: pure bit-serial.
- cnt width is max(1, clog2(NDIG)).
- Elaboration-time error if WIDTH%DIGIT != 0 or DIGIT<1.

Decomposition:
- Shared package (adder_pkg):
  - state enum {IDLE, RUN, DONE};
  - function computing counter width from NDIG.
- Sub-module digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
  - Inputs: a_d, b_d, c_in.
  - Outputs: s_d, c_out, c_msb (carry into the top bit, used for ovf).
- Top level contains the FSM, counter, shift registers and output registers.

Test Plan:
- Overflow add, WIDTH=8, DIGIT=4: a=0x7F, b=0x01, sub=0, cin=0 -> done exactly 3 clocks after the start edge; s=0x80, cout=0, ovf=1; busy high 2 cycles.
- Carry-in chain, WIDTH=8, DIGIT=4: a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1, ovf=0.
- Subtract with borrow, WIDTH=8, DIGIT=4: a=0x05, b=0x07, sub=1, cin=1 -> s=0xFE, cout=0, ovf=0; cin ignored.
- Start while busy:
  - Second start pulse with a=0x11 during RUN -> ignored; single done; result of the first operation only.
  - Then s stays stable through IDLE until the next accepted start.
- Reset mid-operation: assert rst_n=0 in the 2nd RUN cycle -> busy, done, s, cout, ovf go to 0 immediately; after release no done appears without a new start.
- Parameter sweep, (WIDTH, DIGIT) in {(8,1), (8,8), (32,4), (16,2)}: 1000 random a/b/cin/sub vectors -> s, cout, ovf match reference arithmetic; done latency = WIDTH/DIGIT + 1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM states and sizing helpers for the serial adder family.
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cntWidth(input int nDig);
    return nDig > 1 ? $clog2(nDig) : 1;
  endfunction
endpackage

// File: rtl/digit_serial_adder_digit.sv
// digit_adder: combinational DIGIT-bit ripple chain of full-adder cells.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb
);
  logic [DIGIT:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < DIGIT; i++) begin : gFa
    assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
    assign c[i + 1] = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
  end
  assign c_out = c[DIGIT];
  // carry into the top bit, needed for signed overflow of the full word
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock through one shared ripple adder.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cntWidth(NDIG);
  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : gBadParams
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end
  state_t           state, nextState;
  logic [WIDTH-1:0] opA, opB, res, resNext;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] sumD;
  logic             carry, cOut, cMsb, lastDig;
  digit_adder #(.DIGIT(DIGIT)) uAdd (
    .a_d  (opA[DIGIT-1:0]),
    .b_d  (opB[DIGIT-1:0]),
    .c_in (carry),
    .s_d  (sumD),
    .c_out(cOut),
    .c_msb(cMsb)
  );
  assign lastDig = cnt == CW'(NDIG - 1);
  // new digit enters at the top; after NDIG shifts the word is LSB-aligned
  assign resNext = (res >> DIGIT) | (WIDTH'(sumD) << (WIDTH - DIGIT));
  assign busy    = state == RUN;
  assign done    = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (lastDig ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA   <= '0;
      opB   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      opA   <= a;
      opB   <= sub ? ~b : b;
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      opA   <= opA >> DIGIT;
      opB   <= opB >> DIGIT;
      res   <= resNext;
      carry <= cOut;
      cnt   <= cnt + 1'b1;
      if (lastDig) begin
        s    <= resNext;
        cout <= cOut;
        ovf  <= cMsb ^ cOut;
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed checks on an 8/4 instance plus a random sweep over four geometries.
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, sub0 = 1'b0, cin0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic       busy0, done0, cout0, ovf0;
  logic [7:0] s0;
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));

  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1, busy2, done2, cout2, ovf2;
  logic        busy3, done3, cout3, ovf3, busy4, done4, cout4, ovf4;
  logic [7:0]  s1, s2;
  logic [31:0] s3;
  logic [15:0] s4;
  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1[7:0]), .b(b1[7:0]), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1[7:0]), .b(b1[7:0]), .cin(cin1),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));
  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy3), .done(done3), .s(s3), .cout(cout3), .ovf(ovf3));
  digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1[15:0]), .b(b1[15:0]), .cin(cin1),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference result {ovf, cout, s} for a w-bit operation
  function automatic logic [63:0] refOp(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [32:0] m, xa, ya, full;
    logic [31:0] sm;
    logic        co, ov;
    m    = (33'd1 << w) - 33'd1;
    xa   = {1'b0, x} & m;
    ya   = (sb ? {1'b0, ~y} : {1'b0, y}) & m;
    full = xa + ya + 33'(sb | ci);
    sm   = full[31:0] & m[31:0];
    co   = full[w];
    ov   = (xa[w-1] == ya[w-1]) && (sm[w-1] != xa[w-1]);
    return {30'b0, ov, co, sm};
  endfunction

  // one directed 8/4 operation: busy for two cycles, done on the third
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci,
                     input logic sb, input logic [7:0] es, input logic ec, input logic eo);
    a0 = x; b0 = y; cin0 = ci; sub0 = sb; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check({tag, "_run1"}, 64'({busy0, done0}), 64'b10);
    tick();
    check({tag, "_run2"}, 64'({busy0, done0}), 64'b10);
    tick();
    check({tag, "_done"}, 64'({busy0, done0}), 64'b01);
    check({tag, "_res"}, 64'({ovf0, cout0, s0}), 64'({eo, ec, es}));
    tick();
    check({tag, "_idle"}, 64'({busy0, done0}), 64'b00);
  endtask

  initial begin
    logic [63:0] e1, e2, e3, e4;
    tick();
    tick();
    check("reset_outs", 64'({busy0, done0, ovf0, cout0, s0}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 64'({busy0, done0}), 64'b00);

    op8("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("cin_chain", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_ok", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // second start with new operands during RUN must be ignored
    a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
    tick();
    a0 = 8'h11;
    check("busy_start_hold", 64'(s0), 64'h7F);
    tick();
    start0 = 1'b0;
    tick();
    check("busy_start_done", 64'({done0, s0}), 64'({1'b1, 8'h30}));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_second_done", 64'({busy0, done0, s0}), 64'({2'b00, 8'h30}));
    end

    // asynchronous abort in the second RUN cycle
    a0 = 8'h7F; b0 = 8'h01; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("abort_pre", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", 64'({busy0, done0, ovf0, cout0, s0}), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_done", 64'({busy0, done0, s0}), 64'd0);
    end

    for (int v = 0; v < 1000; v++) begin
      a1 = $urandom; b1 = $urandom; cin1 = 1'($urandom); sub1 = 1'($urandom);
      e1 = refOp(8, a1, b1, cin1, sub1);
      e2 = refOp(8, a1, b1, cin1, sub1);
      e3 = refOp(32, a1, b1, cin1, sub1);
      e4 = refOp(16, a1, b1, cin1, sub1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("sw81_done", 64'(done1), 64'(k == 8));
        check("sw88_done", 64'(done2), 64'(k == 1));
        check("sw324_done", 64'(done3), 64'(k == 8));
        check("sw162_done", 64'(done4), 64'(k == 8));
        if (k == 1) check("sw88_res", 64'({ovf2, cout2, 24'b0, s2}), e2);
        if (k == 8) begin
          check("sw81_res", 64'({ovf1, cout1, 24'b0, s1}), e1);
          check("sw324_res", 64'({ovf3, cout3, s3}), e3);
          check("sw162_res", 64'({ovf4, cout4, 16'b0, s4}), e4);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
